// File: rtl/fir_mac_serial.sv
// fir_mac_serial
//   Serial FIR filter: y[n] = sat(sum_{k=0..ORDER} Ck * x[n-k]).
//   A single multiplier-accumulator is time-shared over the ORDER+1 taps,
//   one product per clock.
//   The result is kept at full precision in the accumulator. It is
//   saturated to WORD_SIZE_OUT bits only on the way out.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rat        synchronous active-high reset
//   data_in    unsigned input sample x[n]
//   in_valid   data_in valid
//   in_ready   block can take a sample (IDLE, and rat low)
//   data_out   saturated filter output y[n]
//   out_valid  data_out valid (HOLD)
//   out_ready  downstream accepts data_out; ignored outside HOLD
//   busy       high while computing or holding a result
//
// Timing
//   The accept edge is followed by ORDER+1 MAC edges. out_valid rises after
//   the last of these and stays up until an edge with out_ready=1.
module fir_mac_serial #(
  parameter int          ORDER         = 8,
  parameter int          WORD_SIZE_IN  = 8,
  parameter int          WORD_SIZE_OUT = 16,
  parameter int          ACC_W         = 20,
  parameter logic [7:0]  C0            = 8'd7,
  parameter logic [7:0]  C1            = 8'd46,
  parameter logic [7:0]  C2            = 8'd32,
  parameter logic [7:0]  C3            = 8'd9,
  parameter logic [7:0]  C4            = 8'd0,
  parameter logic [7:0]  C5            = 8'd0,
  parameter logic [7:0]  C6            = 8'd0,
  parameter logic [7:0]  C7            = 8'd0,
  parameter logic [7:0]  C8            = 8'd0
) (
  input  logic                     clk,
  input  logic                     rat,
  input  logic [WORD_SIZE_IN-1:0]  data_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WORD_SIZE_OUT-1:0] data_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int COEF_W = 8;
  localparam int PROD_W = WORD_SIZE_IN + COEF_W;
  localparam int IDX_W  = (ORDER > 0) ? $clog2(ORDER + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ORDER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Only nine coefficient parameters exist. Any tap above C8 multiplies
  // by zero.
  function automatic logic [COEF_W-1:0] coef_const(input int k);
    case (k)
      0:       return C0;
      1:       return C1;
      2:       return C2;
      3:       return C3;
      4:       return C4;
      5:       return C5;
      6:       return C6;
      7:       return C7;
      8:       return C8;
      default: return '0;
    endcase
  endfunction

  state_t                   state_reg, state_next;
  logic [WORD_SIZE_IN-1:0]  x_reg [0:ORDER];
  logic [ACC_W-1:0]         acc_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic [WORD_SIZE_OUT-1:0] data_out_reg;

  logic [COEF_W-1:0]        coef_tab [0:ORDER];
  logic [COEF_W-1:0]        coef_sel;
  logic [WORD_SIZE_IN-1:0]  x_sel;
  logic [PROD_W-1:0]        prod;
  logic [ACC_W-1:0]         sum_next;
  logic [WORD_SIZE_OUT-1:0] sum_sat;

  // This is a constant coefficient ROM. idx_reg selects the entry through
  // a mux.
  genvar gi;
  generate
    for (gi = 0; gi <= ORDER; gi++) begin : g_coef
      assign coef_tab[gi] = coef_const(gi);
    end
  endgenerate

  assign coef_sel = coef_tab[idx_reg];
  assign x_sel    = x_reg[idx_reg];
  assign prod     = PROD_W'(coef_sel) * PROD_W'(x_sel);
  assign sum_next = acc_reg + ACC_W'(prod);

  // ACC_W is sized so the sum never wraps. Any bit set above the output
  // width means the result overflows.
  assign sum_sat  = (|sum_next[ACC_W-1:WORD_SIZE_OUT]) ? '1
                                                        : sum_next[WORD_SIZE_OUT-1:0];

  assign data_out = data_out_reg;

  // State register
  always_ff @(posedge clk) begin
    if (rat) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Reset overrides the transfer, so ready is withheld while rat is up.
        in_ready = ~rat;
        if (in_valid) begin
          state_next = ST_MAC;
        end
      end
      ST_MAC: begin
        busy = 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Delay line, accumulator, tap index and output register
  always_ff @(posedge clk) begin
    if (rat) begin
      for (int k = 0; k <= ORDER; k++) begin
        x_reg[k] <= '0;
      end
      acc_reg      <= '0;
      idx_reg      <= '0;
      data_out_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            x_reg[0] <= data_in;
            for (int k = 1; k <= ORDER; k++) begin
              x_reg[k] <= x_reg[k-1];
            end
            acc_reg <= '0;
            idx_reg <= '0;
          end
        end
        ST_MAC: begin
          acc_reg <= sum_next;
          if (idx_reg == LAST_IDX) begin
            data_out_reg <= sum_sat;
            // idx_reg is parked at 0 so that it never addresses past the
            // end of the delay line while the block sits in HOLD.
            idx_reg      <= '0;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_serial.sv
module tb_fir_mac_serial;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rat;
  logic [7:0]  data_in;
  logic        in_valid;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_busy;
  logic [15:0] a_data_out;
  logic        s_in_ready, s_out_valid, s_busy;
  logic [15:0] s_data_out;

  // Default coefficients
  fir_mac_serial dut_a (
    .clk       (clk),
    .rat       (rat),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .data_out  (a_data_out),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .busy      (a_busy)
  );

  // All coefficients 255, so the output saturates
  fir_mac_serial #(
    .C0(8'd255), .C1(8'd255), .C2(8'd255), .C3(8'd255), .C4(8'd255),
    .C5(8'd255), .C6(8'd255), .C7(8'd255), .C8(8'd255)
  ) dut_s (
    .clk       (clk),
    .rat       (rat),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .data_out  (s_data_out),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .busy      (s_busy)
  );

  int tcount = 0;
  always @(posedge clk) tcount <= tcount + 1;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    if (obs !== expv) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d)", tag, obs, expv, tcount);
    end
  endtask

  // Reference model: sample history, coefficient sets and a transaction timeline
  int hist [9];
  int CA   [9] = '{7, 46, 32, 9, 0, 0, 0, 0, 0};
  int CS   [9] = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
  bit inflight;
  int acc_t;
  int ya, ys;
  int pend[$];
  int ready_delay;
  bit rat_cmd;
  int acc_edges[$];
  int log_a[$];
  int log_s[$];

  function automatic int fir(input int c [9], input int h [9]);
    int y = 0;
    for (int k = 0; k < 9; k++) y += c[k] * h[k];
    return (y > 65535) ? 65535 : y;
  endfunction

  // One clock cycle. Inputs are driven at the negedge, and outputs are
  // checked 1 time unit later. The model is then advanced to what the
  // next posedge must do.
  task automatic cycle();
    bit exp_ov, exp_ir;
    int age;
    @(negedge clk);
    exp_ov = inflight && (tcount >= acc_t + 9);
    age    = tcount - (acc_t + 9);
    rat    = rat_cmd;
    if (exp_ov) out_ready = (age >= ready_delay);
    else        out_ready = 1'($urandom_range(0, 1));
    in_valid = (pend.size() > 0);
    data_in  = in_valid ? 8'(pend[0]) : 8'($urandom_range(0, 255));
    exp_ir   = !rat_cmd && !inflight;
    #1;
    check("a_in_ready",  32'(a_in_ready),  32'(exp_ir));
    check("s_in_ready",  32'(s_in_ready),  32'(exp_ir));
    check("a_out_valid", 32'(a_out_valid), 32'(exp_ov));
    check("s_out_valid", 32'(s_out_valid), 32'(exp_ov));
    check("a_busy",      32'(a_busy),      32'(inflight));
    check("s_busy",      32'(s_busy),      32'(inflight));
    if (exp_ov) begin
      check("a_data_out", 32'(a_data_out), 32'(ya));
      check("s_data_out", 32'(s_data_out), 32'(ys));
    end
    if (rat_cmd) begin
      inflight = 1'b0;
      hist = '{default: 0};
    end else begin
      if (exp_ov && out_ready) begin
        inflight = 1'b0;
        log_a.push_back(int'(a_data_out));
        log_s.push_back(int'(s_data_out));
        $display("t=%0d out: a=%0d (exp %0d) s=%0d (exp %0d)",
                 tcount, a_data_out, ya, s_data_out, ys);
      end
      if (in_valid && exp_ir) begin
        for (int k = 8; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = pend.pop_front();
        ya = fir(CA, hist);
        ys = fir(CS, hist);
        inflight = 1'b1;
        acc_t = tcount + 1;
        acc_edges.push_back(acc_t);
      end
    end
  endtask

  task automatic drain();
    int budget = 0;
    while ((pend.size() > 0 || inflight) && budget < 5000) begin
      cycle();
      budget++;
    end
    if (budget >= 5000) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_log(input string tag, input int got[$], input int expq[$]);
    check({tag, "_count"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      check(tag, 32'(got[i]), 32'(expq[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int expq[$];
    int budget;

    rat = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
    ready_delay = 0; inflight = 1'b0; acc_t = 0; ya = 0; ys = 0;
    hist = '{default: 0};

    // Reset, 2 cycles with rat high
    @(posedge clk);
    rat_cmd = 1'b1;
    cycle();
    check("reset_a_data_out", 32'(a_data_out), 32'd0);
    check("reset_s_data_out", 32'(s_data_out), 32'd0);
    cycle();
    rat_cmd = 1'b0;

    // Impulse
    log_a.delete(); log_s.delete();
    pend = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drain();
    expq = '{7, 46, 32, 9, 0, 0, 0, 0, 0, 0};
    check_log("impulse", log_a, expq);

    // Step of 255. The saturating instance sees the same step.
    log_a.delete(); log_s.delete();
    for (int i = 0; i < 10; i++) pend.push_back(255);
    drain();
    expq = '{1785, 13515, 21675, 23970, 23970, 23970, 23970, 23970, 23970, 23970};
    check_log("step", log_a, expq);
    expq = '{65025, 65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535};
    check_log("saturate", log_s, expq);

    // Backpressure: out_ready is held low for 5 cycles while the 200 sample
    // waits with in_valid high.
    log_a.delete(); log_s.delete(); acc_edges.delete();
    ready_delay = 5;
    pend = '{77, 200};
    drain();
    check("bp_accepts", 32'(acc_edges.size()), 32'd2);
    check("bp_outputs", 32'(log_a.size()), 32'd2);
    ready_delay = 0;

    // Reset during the 4th MAC cycle of a primed history
    for (int i = 0; i < 9; i++) pend.push_back(255);
    drain();
    log_a.delete(); log_s.delete();
    pend = '{255};
    budget = 0;
    while (!inflight && budget < 50) begin cycle(); budget++; end
    if (budget >= 50) check("abort_accept_timeout", 32'd1, 32'd0);
    cycle(); cycle(); cycle();
    rat_cmd = 1'b1;
    cycle();
    rat_cmd = 1'b0;
    pend = '{10};
    drain();
    expq = '{70};
    check_log("after_abort", log_a, expq);

    // Throughput with continuous valid and ready
    acc_edges.delete();
    for (int i = 0; i < 12; i++) pend.push_back($urandom_range(0, 255));
    drain();
    for (int i = 1; i < acc_edges.size(); i++)
      check("accept_spacing", 32'(acc_edges[i] - acc_edges[i-1]), 32'd11);

    // Random samples with random downstream stalls
    for (int b = 0; b < 4; b++) begin
      ready_delay = $urandom_range(0, 3);
      for (int i = 0; i < 8; i++) pend.push_back($urandom_range(0, 255));
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
